// File: rtl/fpu_sub_arbiter_if.sv
// fpu_sub_arbiter_if: requester, result and shared-subtractor handshake bundle for fpu_sub_arbiter
interface fpu_sub_arbiter_if #(parameter int WIDTH = 32);
  logic [2*WIDTH-1:0] req_a, req_b;
  logic [1:0] req_stb, req_ack, res_stb, res_ack;
  logic [WIDTH-1:0] res_z, sub_a, sub_b, sub_z;
  logic sub_a_stb, sub_b_stb, sub_a_ack, sub_b_ack, sub_z_stb, sub_z_ack, owner, busy;
  modport slave (
    input req_a, req_b, req_stb, res_ack, sub_a_ack, sub_b_ack, sub_z, sub_z_stb,
    output req_ack, res_z, res_stb, sub_a, sub_b, sub_a_stb, sub_b_stb, sub_z_ack, owner, busy
  );
  modport master (
    output req_a, req_b, req_stb, res_ack, sub_a_ack, sub_b_ack, sub_z, sub_z_stb,
    input req_ack, res_z, res_stb, sub_a, sub_b, sub_a_stb, sub_b_stb, sub_z_ack, owner, busy
  );
endinterface

// File: rtl/fpu_sub_arbiter.sv
// fpu_sub_arbiter: round-robin sharing of one subtractor between two requesters
module fpu_sub_arbiter #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  fpu_sub_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_Z, DELIVER} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, z_q;
  logic owner_q, last_grant, a_pend, b_pend;
  logic grant, start, a_xfer, b_xfer, z_xfer, done;
  always_comb begin
    grant = (&bus.req_stb) ? ~last_grant : bus.req_stb[1];
    start = state == IDLE && |bus.req_stb && !rst;
    a_xfer = bus.sub_a_stb && bus.sub_a_ack;
    b_xfer = bus.sub_b_stb && bus.sub_b_ack;
    z_xfer = bus.sub_z_ack && bus.sub_z_stb;
    done = state == DELIVER && bus.res_ack[owner_q];
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start ? ISSUE : IDLE;
      ISSUE: state_nxt = ((!a_pend || a_xfer) && (!b_pend || b_xfer)) ? WAIT_Z : ISSUE;
      WAIT_Z: state_nxt = z_xfer ? DELIVER : WAIT_Z;
      DELIVER: state_nxt = done ? IDLE : DELIVER;
      default: state_nxt = IDLE;
    endcase
  end
  // every output decodes registered state, so async reset clears them without an edge
  assign bus.req_ack = start ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.res_stb = state == DELIVER ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.sub_a_stb = state == ISSUE && a_pend;
  assign bus.sub_b_stb = state == ISSUE && b_pend;
  assign bus.sub_z_ack = state == WAIT_Z;
  assign bus.sub_a = a_q;
  assign bus.sub_b = b_q;
  assign bus.res_z = z_q;
  assign bus.owner = owner_q;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      z_q <= '0;
      owner_q <= 1'b0;
      last_grant <= 1'b1;
      a_pend <= 1'b0;
      b_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        a_q <= grant ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
        b_q <= grant ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
        owner_q <= grant;
        a_pend <= 1'b1;
        b_pend <= 1'b1;
      end
      if (a_xfer) a_pend <= 1'b0;
      if (b_xfer) b_pend <= 1'b0;
      if (z_xfer) z_q <= bus.sub_z;
      if (done) last_grant <= owner_q;
    end
  end
endmodule

// File: tb/tb_fpu_sub_arbiter.sv
// tb_fpu_sub_arbiter: vector table plus corner sequences against a behavioural subtractor
module tb_fpu_sub_arbiter;
  typedef struct {int r; logic [31:0] a, b, z;} vec_t;
  typedef struct {int r; logic [31:0] z;} sb_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int a_dly = 1, b_dly = 1, z_dly = 0;
  int ca = 0, cb = 0, cz = 0;
  logic got_a = 1'b0, got_b = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  sb_t sb[$];
  vec_t tbl [6];
  fpu_sub_arbiter_if #(.WIDTH(32)) bus();
  fpu_sub_arbiter #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:23] == 8'd0) return 0.0;
    d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction
  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction
  // subtractor: captures operands on transfer edges, acks after configurable delays
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      got_a <= 1'b0;
      got_b <= 1'b0;
    end else begin
      if (bus.sub_a_stb && bus.sub_a_ack) begin op_a <= bus.sub_a; got_a <= 1'b1; end
      if (bus.sub_b_stb && bus.sub_b_ack) begin op_b <= bus.sub_b; got_b <= 1'b1; end
      if (bus.sub_z_stb && bus.sub_z_ack) begin got_a <= 1'b0; got_b <= 1'b0; end
    end
  end
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      ca = 0; cb = 0; cz = 0;
      bus.sub_a_ack = 1'b0;
      bus.sub_b_ack = 1'b0;
      bus.sub_z_stb = 1'b0;
      bus.sub_z = '0;
    end else begin
      ca = bus.sub_a_stb ? ca + 1 : 0;
      cb = bus.sub_b_stb ? cb + 1 : 0;
      bus.sub_a_ack = bus.sub_a_stb && ca >= a_dly;
      bus.sub_b_ack = bus.sub_b_stb && cb >= b_dly;
      cz = (got_a && got_b) ? cz + 1 : 0;
      bus.sub_z_stb = cz > z_dly;
      bus.sub_z = r2s(s2r(op_a) - s2r(op_b));
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic send(input int r, input logic [31:0] a, input logic [31:0] b, input logic [31:0] z, input bit push);
    int n = 0;
    bus.req_a[r*32 +: 32] = a;
    bus.req_b[r*32 +: 32] = b;
    bus.req_stb[r] = 1'b1;
    @(negedge clk);
    while (!bus.req_ack[r] && n < 100) begin @(negedge clk); n++; end
    chk("req_ack", bus.req_ack, 64'd1 << r);
    @(posedge clk); #1;
    bus.req_stb[r] = 1'b0;
    chk("owner", bus.owner, r);
    chk("busy", bus.busy, 1);
    if (push) sb.push_back('{r, z});
  endtask
  task automatic receive();
    int n = 0;
    sb_t e;
    @(negedge clk);
    while (bus.res_stb == 2'b00 && n < 100) begin @(negedge clk); n++; end
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty actual=%0h expected=none", bus.res_stb);
    end else begin
      e = sb.pop_front();
      chk("res_stb", bus.res_stb, 64'd1 << e.r);
      chk("res_z", bus.res_z, e.z);
    end
    bus.res_ack = bus.res_stb;
    @(posedge clk); #1;
    bus.res_ack = 2'b00;
    chk("idle_after_ack", bus.busy, 0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    tbl[0] = '{0, 32'h417C0000, 32'h40E80000, 32'h41080000};
    tbl[1] = '{1, 32'h00000000, 32'h40E80000, 32'hC0E80000};
    tbl[2] = '{0, 32'h40000000, 32'h3F800000, 32'h3F800000};
    tbl[3] = '{1, 32'h3F800000, 32'h40000000, 32'hBF800000};
    tbl[4] = '{1, 32'h40400000, 32'h3F000000, 32'h40200000};
    tbl[5] = '{0, 32'h41200000, 32'h41200000, 32'h00000000};
    bus.req_a = '0;
    bus.req_b = '0;
    bus.res_ack = 2'b00;
    bus.req_stb = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ack", bus.req_ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_res_stb", bus.res_stb, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_res_z", bus.res_z, 0);
    bus.req_stb = 2'b00;
    rst = 1'b0;
    @(posedge clk); #1;
    foreach (tbl[i]) begin
      send(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].z, 1'b1);
      receive();
    end
    // operand acks split across ISSUE cycles 2 and 5
    a_dly = 2; b_dly = 5; z_dly = 1;
    send(0, 32'h40400000, 32'h3F000000, 32'h40200000, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("split_a_stb", bus.sub_a_stb, k <= 2);
      chk("split_b_stb", bus.sub_b_stb, k <= 5);
      chk("split_z_ack", bus.sub_z_ack, k == 6);
      chk("split_sub_a", bus.sub_a, 32'h40400000);
      chk("split_sub_b", bus.sub_b, 32'h3F000000);
    end
    receive();
    a_dly = 1; b_dly = 1; z_dly = 0;
    // result withheld while r1 waits; stray non-owner res_ack must be ignored
    send(0, 32'h417C0000, 32'h40E80000, 32'h41080000, 1'b1);
    bus.req_a[63:32] = 32'h41200000;
    bus.req_b[63:32] = 32'h3F800000;
    bus.req_stb[1] = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.res_stb == 2'b00 && n < 100) begin @(negedge clk); n++; end
    bus.res_ack = 2'b10;
    for (int k = 0; k < 10; k++) begin
      chk("hold_res_stb", bus.res_stb, 2'b01);
      chk("hold_res_z", bus.res_z, 32'h41080000);
      chk("hold_req_ack", bus.req_ack, 0);
      @(negedge clk);
    end
    bus.res_ack = 2'b00;
    receive();
    @(negedge clk);
    chk("regrant_r1", bus.req_ack, 2'b10);
    @(posedge clk); #1;
    bus.req_stb = 2'b00;
    sb.push_back('{1, 32'h41100000});
    receive();
    // both requesters held from reset
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_a = {32'h40400000, 32'h40000000};
    bus.req_b = {32'h3F000000, 32'h3F800000};
    bus.req_stb = 2'b11;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      @(negedge clk);
      while (bus.req_ack == 2'b00 && n < 100) begin @(negedge clk); n++; end
      chk("fair_grant", bus.req_ack, (i % 2) ? 2'b10 : 2'b01);
      sb.push_back('{i % 2, (i % 2) ? 32'h40200000 : 32'h3F800000});
      @(posedge clk); #1;
      receive();
    end
    bus.req_stb = 2'b00;
    // reset during WAIT_Z abandons the transaction
    z_dly = 20;
    send(1, 32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0);
    n = 0;
    @(negedge clk);
    while (!bus.sub_z_ack && n < 100) begin @(negedge clk); n++; end
    chk("in_wait_z", bus.sub_z_ack, 1);
    #2;
    bus.req_stb = 2'b01;
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ack", bus.req_ack, 0);
    chk("mid_rst_res_stb", bus.res_stb, 0);
    chk("mid_rst_sub_a_stb", bus.sub_a_stb, 0);
    chk("mid_rst_sub_b_stb", bus.sub_b_stb, 0);
    chk("mid_rst_sub_z_ack", bus.sub_z_ack, 0);
    chk("mid_rst_owner", bus.owner, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_sub_a", bus.sub_a, 0);
    chk("mid_rst_sub_b", bus.sub_b, 0);
    chk("mid_rst_res_z", bus.res_z, 0);
    @(posedge clk); #1;
    bus.req_stb = 2'b00;
    rst = 1'b0;
    z_dly = 0;
    send(0, 32'h40000000, 32'h3F800000, 32'h3F800000, 1'b1);
    receive();
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_sub_arbiter.md
FPU_SUB_ARBITER -- requirements
Module: fpu_sub_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (IEEE-754 single).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  one clock; reset is asynchronous and active-high.
REQ-004 req_a  in  2*WIDTH  operand A per requester; [WIDTH-1:0]=requester 0, [2*WIDTH-1:WIDTH]=requester 1.
REQ-005 req_b  in  2*WIDTH  operand B per requester, same packing; result = A - B.
REQ-006 req_stb  in  2  per-requester operand strobe; held high until matching req_ack.
REQ-007 req_ack  out  2  per-requester operand accept; one-hot or zero.
REQ-008 res_z  out  WIDTH  shared result bus, valid for the requester whose res_stb is high.
REQ-009 res_stb  out  2  per-requester result valid; one-hot or zero.
REQ-010 res_ack  in  2  per-requester result accept.
REQ-011 sub_a, sub_b  out  WIDTH each  operands to shared subtractor.
REQ-012 sub_a_stb, sub_b_stb  out  1 each  operand strobes to subtractor.
REQ-013 sub_a_ack, sub_b_ack  in  1 each  operand accepts from subtractor.
REQ-014 sub_z  in  WIDTH; sub_z_stb  in  1; sub_z_ack  out  1  subtractor result handshake.
REQ-015 owner  out  1  requester index of current transaction; busy  out  1  high when state != IDLE.

Function
REQ-016 A handshake transfer SHALL occur on a rising edge where stb and ack are both high; no other condition transfers data.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT_Z, DELIVER; one transaction in flight at most.
REQ-018 IDLE: grant = round-robin over req_stb; single requester wins; on tie, the requester != last_grant wins.
REQ-019 IDLE: req_ack[g] SHALL be combinationally high with the grant (same cycle as req_stb); at that edge latch req_a/req_b slice g into operand registers, owner<=g, set a_pend=b_pend=1, go ISSUE.
REQ-020 ISSUE: sub_a_stb=a_pend, sub_b_stb=b_pend; sub_a/sub_b driven from latched registers, stable for the whole transaction.
REQ-021 ISSUE: a_pend clears on the edge where sub_a_stb && sub_a_ack; b_pend likewise, independently; acks may arrive in the same or different cycles.
REQ-022 ISSUE -> WAIT_Z on the edge where the last pending operand transfers; minimum one cycle in ISSUE.
REQ-023 WAIT_Z: sub_z_ack=1; on edge with sub_z_stb high, capture sub_z into result register, go DELIVER; sub_z_ack=0 in every other state.
REQ-024 DELIVER: res_stb[owner]=1, res_z=captured result; on edge with res_ack[owner], last_grant<=owner, go IDLE.
REQ-025 res_ack of non-owner and req_stb during busy SHALL be ignored; pending req_stb is served at the next IDLE.
REQ-026 Minimum latency req_ack to res_stb: 3 cycles (1 ISSUE, 1 WAIT_Z, entry to DELIVER), plus subtractor latency.
REQ-027 Fairness: with both requesters continuously requesting, grants SHALL strictly alternate.
REQ-028 No DELIVER -> IDLE same-cycle regrant: new grant occurs no earlier than the cycle after returning to IDLE.
REQ-029 res_z SHALL hold last captured value outside DELIVER; consumers qualify with res_stb.

Reset
REQ-030 rst high SHALL immediately force: state IDLE, req_ack=0, res_stb=0, sub_a_stb=sub_b_stb=0, sub_z_ack=0, owner=0, busy=0, a_pend=b_pend=0, operand/result registers=0, last_grant=1 (requester 0 wins first tie).
REQ-031 Reset mid-transaction SHALL abandon it with no result delivered; the subtractor shares rst and is reset jointly.

Verification
REQ-032 r0 only, A=0x417C0000 (15.75), B=0x40E80000 (7.25) -> req_ack[0] one cycle, owner=0, res_stb[0] with res_z=0x41080000 (8.5).
REQ-033 A=0x00000000, B=0x40E80000 from r1 -> res_stb[1], res_z=0xC0E80000 (-7.25), res_stb[0] stays 0.
REQ-034 Both req_stb high from reset, each held -> order r0, r1, r0, r1; no two consecutive grants to one requester.
REQ-035 Subtractor model acks A at cycle 2, B at cycle 5 of ISSUE -> sub_a_stb low from cycle 3, sub_b_stb high through cycle 5, WAIT_Z entered only after B edge.
REQ-036 res_ack withheld 10 cycles in DELIVER while r1 requests -> res_stb/res_z stable, req_ack[1]=0 until after r0 result accepted.
REQ-037 rst asserted during WAIT_Z -> all outputs at REQ-030 values without a clock edge; next request after release completes normally.
